// File: rtl/if_fetch.sv
// rtl/if_fetch.sv - instruction fetch stage feeding ID through an in-order fetch queue
// Define IF_BYPASS_EN to forward a response arriving at an empty queue straight to ID.
module if_fetch #(
   parameter int              XLEN        = 32,
   parameter logic [XLEN-1:0] RESET_PC    = '0,
   parameter int              QUEUE_DEPTH = 2
) (
   input  logic            clk,
   input  logic            rst,
   output logic            imem_req,
   output logic [XLEN-1:0] imem_addr,
   input  logic            imem_gnt,
   input  logic            imem_rvalid,
   input  logic [XLEN-1:0] imem_rdata,
   input  logic            id_pipe_ready,
   input  logic            id_pipe_flush,
   output logic            id_pipe_valid,
   output logic [XLEN-1:0] id_pipe_pc,
   output logic [XLEN-1:0] id_pipe_instruction,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc
);

   localparam int PW = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
   localparam int CW = PW + 1;

   typedef enum logic {
      S_IDLE,
      S_REQ
   } state_t;

   state_t          r_state;
   state_t          w_state_next;
   logic            w_load;

   logic [XLEN-1:0] r_pc;
   logic [XLEN-1:0] r_req_addr;
   logic            r_stale;
   logic [CW-1:0]   r_out;
   logic [CW-1:0]   r_discard;

   logic [XLEN-1:0] r_tq [QUEUE_DEPTH];
   logic [PW-1:0]   r_tq_wp;
   logic [PW-1:0]   r_tq_rp;

   logic [XLEN-1:0] r_fq_pc  [QUEUE_DEPTH];
   logic [XLEN-1:0] r_fq_ins [QUEUE_DEPTH];
   logic [PW-1:0]   r_fq_wp;
   logic [PW-1:0]   r_fq_rp;
   logic [CW-1:0]   r_fq_cnt;

   logic            w_flush;
   logic            w_gnt_fire;
   logic            w_drop;
   logic            w_drop_disc;
   logic            w_keep;
   logic            w_empty;
   logic            w_byp;
   logic            w_push;
   logic            w_pop;
   logic            w_stale_next;
   logic            w_can_issue;
   logic [XLEN-1:0] w_tag_pc;
   logic [XLEN-1:0] w_redir_pc;
   logic [XLEN-1:0] w_pc_next;
   logic [CW-1:0]   w_out_next;
   logic [CW-1:0]   w_disc_next;
   logic [CW-1:0]   w_cnt_next;
   logic [CW:0]     w_credit_sum;

   assign w_flush     = redirect_valid | id_pipe_flush;
   assign w_gnt_fire  = (r_state == S_REQ) && imem_gnt;
   assign w_drop_disc = imem_rvalid && (r_discard != '0);
   assign w_drop      = imem_rvalid && ((r_discard != '0) || w_flush);
   assign w_keep      = imem_rvalid && !w_drop;
   assign w_empty     = (r_fq_cnt == '0);
   assign w_tag_pc    = r_tq[r_tq_rp];
   assign w_redir_pc  = redirect_pc & ~XLEN'(3);

`ifdef IF_BYPASS_EN
   assign w_byp = w_keep && w_empty;
`else
   assign w_byp = 1'b0;
`endif

   // A bypassed response that ID takes this cycle never occupies a queue slot.
   assign w_push = w_keep && !(w_byp && id_pipe_ready);
   assign w_pop  = !w_empty && !w_flush && id_pipe_ready;

   assign w_out_next = r_out + CW'(w_gnt_fire) - CW'(imem_rvalid);
   assign w_cnt_next = w_flush ? '0 : (r_fq_cnt + CW'(w_push) - CW'(w_pop));

   always_comb begin
      w_pc_next = r_pc;
      if (redirect_valid)
         w_pc_next = w_redir_pc;
      else if (w_gnt_fire && !r_stale)
         w_pc_next = r_req_addr + XLEN'(4);
   end

   // A request still waiting for grant at a flush belongs to the old path;
   // its response is added to the discard count once it is granted.
   always_comb begin
      w_stale_next = r_stale;
      if (w_flush && (r_state == S_REQ) && !imem_gnt)
         w_stale_next = 1'b1;
      else if (w_gnt_fire)
         w_stale_next = 1'b0;
   end

   always_comb begin
      w_disc_next = r_discard - CW'(w_drop_disc) + CW'(w_gnt_fire && r_stale);
      if (w_flush)
         w_disc_next = w_out_next;
   end

   assign w_credit_sum = {1'b0, w_cnt_next} + {1'b0, w_out_next};
   assign w_can_issue  = !w_flush && (w_credit_sum < (CW+1)'(QUEUE_DEPTH));

   always_comb begin
      w_state_next = r_state;
      w_load       = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_can_issue) begin
               w_state_next = S_REQ;
               w_load       = 1'b1;
            end
         end
         S_REQ: begin
            if (imem_gnt) begin
               if (w_can_issue)
                  w_load = 1'b1;
               else
                  w_state_next = S_IDLE;
            end
         end
         default: w_state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         r_state <= S_IDLE;
      else
         r_state <= w_state_next;
   end

   assign imem_req  = (r_state == S_REQ);
   assign imem_addr = r_req_addr;

   always_comb begin
      id_pipe_valid       = !w_empty && !w_flush;
      id_pipe_pc          = r_fq_pc[r_fq_rp];
      id_pipe_instruction = r_fq_ins[r_fq_rp];
`ifdef IF_BYPASS_EN
      if (w_byp) begin
         id_pipe_valid       = 1'b1;
         id_pipe_pc          = w_tag_pc;
         id_pipe_instruction = imem_rdata;
      end
`endif
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_pc       <= RESET_PC;
         r_req_addr <= RESET_PC;
         r_stale    <= 1'b0;
         r_out      <= '0;
         r_discard  <= '0;
         r_tq_wp    <= '0;
         r_tq_rp    <= '0;
         r_fq_wp    <= '0;
         r_fq_rp    <= '0;
         r_fq_cnt   <= '0;
         for (int i = 0; i < QUEUE_DEPTH; i++) begin
            r_tq[i]     <= '0;
            r_fq_pc[i]  <= '0;
            r_fq_ins[i] <= '0;
         end
      end else begin
         r_pc      <= w_pc_next;
         r_stale   <= w_stale_next;
         r_out     <= w_out_next;
         r_discard <= w_disc_next;
         r_fq_cnt  <= w_cnt_next;
         if (w_load)
            r_req_addr <= w_pc_next;
         if (w_gnt_fire) begin
            r_tq[r_tq_wp] <= r_req_addr;
            r_tq_wp       <= r_tq_wp + PW'(1);
         end
         // Every response retires a tag, whether it is kept or dropped.
         if (imem_rvalid)
            r_tq_rp <= r_tq_rp + PW'(1);
         if (w_push) begin
            r_fq_pc[r_fq_wp]  <= w_tag_pc;
            r_fq_ins[r_fq_wp] <= imem_rdata;
            r_fq_wp           <= r_fq_wp + PW'(1);
         end
         if (w_flush)
            r_fq_rp <= r_fq_wp;
         else if (w_pop)
            r_fq_rp <= r_fq_rp + PW'(1);
      end
   end

   always @(posedge clk) begin
      if (!rst && imem_rvalid)
         a_rvalid_has_outstanding: assert (r_out != '0);
   end

endmodule

// File: tb/tb_if_fetch.sv
// tb/tb_if_fetch.sv - directed self-checking bench for if_fetch
// Memory model grants per imem_gnt and answers one cycle later with data = addr + 0x13.
module tb_if_fetch;

   logic        clk = 1'b0;
   logic        rst;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic        id_pipe_ready;
   logic        id_pipe_flush;
   logic        id_pipe_valid;
   logic [31:0] id_pipe_pc;
   logic [31:0] id_pipe_instruction;
   logic        redirect_valid;
   logic [31:0] redirect_pc;

   int          checks   = 0;
   int          failures = 0;
   int          n_gnt;
   logic [31:0] pend [$];

   if_fetch dut (
      .clk                 (clk),
      .rst                 (rst),
      .imem_req            (imem_req),
      .imem_addr           (imem_addr),
      .imem_gnt            (imem_gnt),
      .imem_rvalid         (imem_rvalid),
      .imem_rdata          (imem_rdata),
      .id_pipe_ready       (id_pipe_ready),
      .id_pipe_flush       (id_pipe_flush),
      .id_pipe_valid       (id_pipe_valid),
      .id_pipe_pc          (id_pipe_pc),
      .id_pipe_instruction (id_pipe_instruction),
      .redirect_valid      (redirect_valid),
      .redirect_pc         (redirect_pc)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (rst) begin
         pend.delete();
         n_gnt = 0;
      end else if (imem_req && imem_gnt) begin
         pend.push_back(imem_addr);
         n_gnt++;
      end
   end

   always @(negedge clk) begin
      if (!rst && pend.size() > 0) begin
         imem_rvalid = 1'b1;
         imem_rdata  = pend.pop_front() + 32'h13;
      end else begin
         imem_rvalid = 1'b0;
         imem_rdata  = 32'h0;
      end
   end

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      rst            = 1'b1;
      redirect_valid = 1'b0;
      id_pipe_flush  = 1'b0;
      redirect_pc    = 32'h0;
      tick();
      tick();
      rst = 1'b0;
   endtask

   initial begin
      rst            = 1'b1;
      imem_gnt       = 1'b1;
      id_pipe_ready  = 1'b1;
      id_pipe_flush  = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = 32'h0;
      tick();
      tick();
      chk("rst_req",   imem_req,            32'h0);
      chk("rst_valid", id_pipe_valid,       32'h0);
      chk("rst_pc",    id_pipe_pc,          32'h0);
      chk("rst_instr", id_pipe_instruction, 32'h0);

`ifdef IF_BYPASS_EN
      id_pipe_ready = 1'b1;
      do_reset();
      tick();
      chk("byp_c1_req",   imem_req,            32'h1);
      chk("byp_c1_valid", id_pipe_valid,       32'h0);
      tick();
      chk("byp_c2_valid", id_pipe_valid,       32'h1);
      chk("byp_c2_pc",    id_pipe_pc,          32'h0);
      chk("byp_c2_instr", id_pipe_instruction, 32'h13);
      chk("byp_c2_addr",  imem_addr,           32'h4);
      tick();
      chk("byp_c3_valid", id_pipe_valid,       32'h1);
      chk("byp_c3_pc",    id_pipe_pc,          32'h4);
      chk("byp_c3_instr", id_pipe_instruction, 32'h17);
      chk("byp_c3_addr",  imem_addr,           32'h8);
      tick();
      chk("byp_c4_pc",    id_pipe_pc,          32'h8);
      chk("byp_c4_instr", id_pipe_instruction, 32'h1B);
`else
      // Streaming fetch with ID always ready.
      rst = 1'b0;
      tick();
      chk("t1_c1_req",   imem_req,            32'h1);
      chk("t1_c1_addr",  imem_addr,           32'h0);
      chk("t1_c1_valid", id_pipe_valid,       32'h0);
      tick();
      chk("t1_c2_addr",  imem_addr,           32'h4);
      chk("t1_c2_valid", id_pipe_valid,       32'h0);
      tick();
      chk("t1_c3_req",   imem_req,            32'h0);
      chk("t1_c3_valid", id_pipe_valid,       32'h1);
      chk("t1_c3_pc",    id_pipe_pc,          32'h0);
      chk("t1_c3_instr", id_pipe_instruction, 32'h13);
      tick();
      chk("t1_c4_addr",  imem_addr,           32'h8);
      chk("t1_c4_pc",    id_pipe_pc,          32'h4);
      chk("t1_c4_instr", id_pipe_instruction, 32'h17);
      tick();
      chk("t1_c5_valid", id_pipe_valid,       32'h0);
      chk("t1_c5_addr",  imem_addr,           32'hC);
      tick();
      chk("t1_c6_pc",    id_pipe_pc,          32'h8);
      chk("t1_c6_instr", id_pipe_instruction, 32'h1B);

      // ID stalled: credit limits fetches to the queue depth.
      id_pipe_ready = 1'b0;
      do_reset();
      tick();
      chk("t2_c1_addr",  imem_addr,     32'h0);
      tick();
      chk("t2_c2_addr",  imem_addr,     32'h4);
      tick();
      chk("t2_c3_req",   imem_req,      32'h0);
      tick();
      chk("t2_c4_req",   imem_req,      32'h0);
      chk("t2_c4_valid", id_pipe_valid, 32'h1);
      tick();
      chk("t2_c5_req",   imem_req,      32'h0);
      chk("t2_c5_gnts",  n_gnt,         32'd2);
      chk("t2_c5_pc",    id_pipe_pc,    32'h0);
      id_pipe_ready = 1'b1;
      tick();
      chk("t2_c6_pc",    id_pipe_pc,          32'h4);
      chk("t2_c6_instr", id_pipe_instruction, 32'h17);
      chk("t2_c6_req",   imem_req,            32'h1);
      chk("t2_c6_addr",  imem_addr,           32'h8);
      tick();
      chk("t2_c7_addr",  imem_addr,           32'hC);

      // Redirect with 0x8 returning and 0xC being granted: both discarded.
      redirect_valid = 1'b1;
      id_pipe_flush  = 1'b1;
      redirect_pc    = 32'h100;
      tick();
      redirect_valid = 1'b0;
      id_pipe_flush  = 1'b0;
      chk("t3_c8_req",    imem_req,            32'h0);
      chk("t3_c8_valid",  id_pipe_valid,       32'h0);
      tick();
      chk("t3_c9_addr",   imem_addr,           32'h100);
      chk("t3_c9_valid",  id_pipe_valid,       32'h0);
      tick();
      chk("t3_c10_valid", id_pipe_valid,       32'h0);
      tick();
      chk("t3_c11_valid", id_pipe_valid,       32'h1);
      chk("t3_c11_pc",    id_pipe_pc,          32'h100);
      chk("t3_c11_instr", id_pipe_instruction, 32'h113);

      // Grant withheld on 0x4 across a redirect to 0x40.
      id_pipe_ready = 1'b1;
      imem_gnt      = 1'b1;
      do_reset();
      tick();
      chk("t4_c1_addr",  imem_addr,     32'h0);
      tick();
      chk("t4_c2_addr",  imem_addr,     32'h4);
      imem_gnt = 1'b0;
      tick();
      chk("t4_c3_addr",  imem_addr,     32'h4);
      chk("t4_c3_pc",    id_pipe_pc,    32'h0);
      redirect_valid = 1'b1;
      id_pipe_flush  = 1'b1;
      redirect_pc    = 32'h40;
      tick();
      redirect_valid = 1'b0;
      id_pipe_flush  = 1'b0;
      chk("t4_c4_req",   imem_req,      32'h1);
      chk("t4_c4_addr",  imem_addr,     32'h4);
      chk("t4_c4_valid", id_pipe_valid, 32'h0);
      tick();
      chk("t4_c5_addr",  imem_addr,     32'h4);
      imem_gnt = 1'b1;
      tick();
      chk("t4_c6_addr",  imem_addr,     32'h40);
      tick();
      chk("t4_c7_valid", id_pipe_valid, 32'h0);
      chk("t4_c7_addr",  imem_addr,     32'h44);
      tick();
      chk("t4_c8_valid", id_pipe_valid,       32'h1);
      chk("t4_c8_pc",    id_pipe_pc,          32'h40);
      chk("t4_c8_instr", id_pipe_instruction, 32'h53);

      // Unaligned redirect target and PC wrap at the top of the address space.
      rst = 1'b1;
      tick();
      tick();
      rst            = 1'b0;
      redirect_valid = 1'b1;
      id_pipe_flush  = 1'b1;
      redirect_pc    = 32'h203;
      tick();
      redirect_valid = 1'b0;
      id_pipe_flush  = 1'b0;
      chk("t5_c1_req",   imem_req,  32'h0);
      tick();
      chk("t5_c2_req",   imem_req,  32'h1);
      chk("t5_c2_addr",  imem_addr, 32'h200);
      redirect_valid = 1'b1;
      id_pipe_flush  = 1'b1;
      redirect_pc    = 32'hFFFF_FFFC;
      tick();
      redirect_valid = 1'b0;
      id_pipe_flush  = 1'b0;
      chk("t5_c3_req",   imem_req,  32'h0);
      tick();
      chk("t5_c4_addr",  imem_addr, 32'hFFFF_FFFC);
      tick();
      chk("t5_c5_addr",  imem_addr, 32'h0);
      tick();
      chk("t5_c6_valid", id_pipe_valid,       32'h1);
      chk("t5_c6_pc",    id_pipe_pc,          32'hFFFF_FFFC);
      chk("t5_c6_instr", id_pipe_instruction, 32'h0000_000F);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/if_fetch.md
Name: if_fetch

Overview:
- Instruction Fetch stage and producer side of the IF->ID pipeline interface.
- Issues word fetches to instruction memory over a req/gnt/rvalid bus and buffers the returned instructions with their PCs in an in-order fetch queue.
- Presents queued instructions to ID using valid/ready/flush.
- Redirects the fetch PC on a taken branch or jump from EX.

Parameters:
- RESET_PC, 32'h0000_0000: first fetch address after reset.
- QUEUE_DEPTH, 2: fetch queue entries; power of two, >=2. Also the maximum in-flight plus buffered fetches.

Ports:
- clk  in  1: clock.
- rst  in  1: reset; asynchronous, active-high.
- imem_req  out  1: fetch request.
- imem_addr  out  XLEN: fetch address, word aligned.
- imem_gnt  in  1: request accepted this cycle.
- imem_rvalid  in  1: read data valid. Responses return in order, at least 1 cycle after gnt.
- imem_rdata  in  XLEN: instruction word.
- id_pipe_ready  in  1: ID accepts the current instruction.
- id_pipe_flush  in  1: flush IF contents. Asserted together with redirect_valid.
- id_pipe_valid  out  1: instruction available to ID.
- id_pipe_pc  out  XLEN: PC of the instruction presented to ID.
- id_pipe_instruction  out  XLEN: instruction presented to ID.
- redirect_valid  in  1: taken branch or jump.
- redirect_pc  in  XLEN: target address; bits [1:0] ignored, treated as 0.

Behaviour:
- Reset values: pc_q=RESET_PC, imem_req=0, queue empty, outstanding=0, discard=0, id_pipe_valid=0. id_pipe_pc and id_pipe_instruction reset to 0.
- Credit check: imem_req rises when queue_count + outstanding < QUEUE_DEPTH, with no redirect in the same cycle.
- Request holding: once imem_req=1, imem_req and imem_addr stay stable until imem_gnt, including across a redirect. imem_addr comes from the req_addr register, not pc_q.
- Grant: on imem_req&imem_gnt, pc_q<=req_addr+4, outstanding++, req_addr is pushed onto the PC tag queue (depth QUEUE_DEPTH). Back-to-back requests are allowed; the next request is issued in the following cycle if credit remains.
- Response: on imem_rvalid, outstanding--.
  - If discard>0: discard--, the PC tag is popped, and the data is dropped.
  - Otherwise {tag_pc, imem_rdata} is pushed onto the fetch queue.
- Output: id_pipe_valid = queue not empty. id_pipe_pc and id_pipe_instruction come from the queue head. Pop on id_pipe_valid & id_pipe_ready.
- Latency: without bypass, id_pipe_valid rises 1 cycle after rvalid into an empty queue.
- Push and pop in the same cycle keep the count unchanged. The credit rule makes overflow impossible; an rvalid with outstanding==0 is an assertion error.
- Redirect/flush, applied as a registered update:
  - Fetch queue cleared.
  - pc_q<=redirect_pc.
  - discard<= outstanding after this cycle's gnt/rvalid. A same-cycle rvalid is dropped and not counted.
  - If a request is pending without grant, it completes, and its response is counted in discard on its gnt.
  - id_pipe_valid=0 in the flush cycle. No pop occurs in that cycle.
- New fetch after redirect: issued at redirect_pc no earlier than the cycle after the redirect and once the pending request (if any) is granted.
- Redirect while discard>0: discard is recomputed by the same rule; no responses are double counted.
- Wrap: pc_q+4 wraps modulo 2^XLEN.
- Reset mid-operation: all state is cleared asynchronously. The instruction memory must be reset concurrently; stale responses are illegal.

Optional Feature:
- Macro: IF_BYPASS_EN.
- Defined: when the queue is empty and a non-discarded rvalid arrives, the response drives the id_pipe outputs combinationally with id_pipe_valid=1 in the same cycle. If id_pipe_ready=1, it is consumed without a push; otherwise it is pushed.
- Undefined: all responses pass through the queue, giving 1 cycle of added latency.

Test Plan:
- Reset release, memory gnt always 1, rvalid 1 cycle later, ready=1 -> fetches at 0x0,0x4,0x8. id_pipe_pc follows 0x0,0x4,0x8; first valid 2 cycles after the first gnt (no bypass).
- ready=0 with QUEUE_DEPTH=2 -> exactly 2 grants, then imem_req=0. Raising ready releases 0x0 and then 0x4, and imem_req resumes at 0x8.
- Two requests outstanding (0x8, 0xC), redirect to 0x100 -> both responses dropped, next valid pc=0x100, no 0x8/0xC seen by ID.
- imem_gnt held low 3 cycles on addr 0x4 while a redirect to 0x40 occurs -> imem_addr stays 0x4 until gnt, its response is dropped, and the next fetch is 0x40.
- redirect_pc=0x203 -> fetch address 0x200. pc_q=0xFFFF_FFFC followed by a grant -> next fetch address 0x0.
- IF_BYPASS_EN defined, empty queue, rvalid with data 0x00000013 and ready=1 -> id_pipe_valid=1 with instruction 0x00000013 in the same cycle, and the queue stays empty.
